// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute-stage HI/LO multiply/divide unit.
// Op codes follow the MULT/MULTU/DIV/DIVU funct ordering used by decode.
package mips_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   function automatic logic md_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/md_twos_negate.sv
// Combinational two's-complement negate, used for operand magnitude and
// result sign correction.
module md_twos_negate #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   output logic [W-1:0] y
);

   assign y = ~a + W'(1);

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, signs fixed at the end.
import mips_pkg::*;

module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam int W2 = 2 * WIDTH;

   logic [1:0]       state;
   logic             div_op;
   logic             neg_a;
   logic             neg_b;
   logic             dz;
   logic             tail;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mb;
   logic [WIDTH-1:0] rs_orig;
   logic [W2-1:0]    acc;

   logic [WIDTH-1:0] rs_neg;
   logic [WIDTH-1:0] rt_neg;
   logic [WIDTH-1:0] abs_rs;
   logic [WIDTH-1:0] abs_rt;
   logic             sa;
   logic             sb;

   md_twos_negate #(.W(WIDTH)) u_neg_rs (.a(rs_val), .y(rs_neg));
   md_twos_negate #(.W(WIDTH)) u_neg_rt (.a(rt_val), .y(rt_neg));

   assign sa     = md_is_signed(op) & rs_val[WIDTH-1];
   assign sb     = md_is_signed(op) & rt_val[WIDTH-1];
   assign abs_rs = sa ? rs_neg : rs_val;
   assign abs_rt = sb ? rt_neg : rt_val;

   // Step datapath; the extra top bit holds the add carry / subtract borrow.
   logic [WIDTH:0]   mul_sum;
   logic [W2-1:0]    mul_next;
   logic [W2:0]      div_shift;
   logic [WIDTH:0]   div_diff;
   logic [W2-1:0]    div_next;

   assign mul_sum  = {1'b0, acc[W2-1:WIDTH]}
                   + (acc[0] ? {1'b0, mb} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   assign div_shift = {acc, 1'b0};
   assign div_diff  = div_shift[W2:WIDTH] - {1'b0, mb};
   assign div_next  = div_diff[WIDTH]
                    ? div_shift[W2-1:0]
                    : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

   logic [W2-1:0]    prod_neg;
   logic [WIDTH-1:0] quot_neg;
   logic [WIDTH-1:0] rem_neg;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   md_twos_negate #(.W(W2))    u_neg_p (.a(acc), .y(prod_neg));
   md_twos_negate #(.W(WIDTH)) u_neg_q (.a(acc[WIDTH-1:0]), .y(quot_neg));
   md_twos_negate #(.W(WIDTH)) u_neg_r (.a(acc[W2-1:WIDTH]), .y(rem_neg));

   always_comb begin
      res_hi = acc[W2-1:WIDTH];
      res_lo = acc[WIDTH-1:0];
      if (!div_op) begin
         if (neg_a ^ neg_b) {res_hi, res_lo} = prod_neg;
      end else if (dz) begin
         res_hi = rs_orig;
         res_lo = '1;
      end else begin
         if (neg_a ^ neg_b) res_lo = quot_neg;
         if (neg_a)         res_hi = rem_neg;
      end
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         div_op  <= 1'b0;
         neg_a   <= 1'b0;
         neg_b   <= 1'b0;
         dz      <= 1'b0;
         tail    <= 1'b0;
         count   <= '0;
         mb      <= '0;
         rs_orig <= '0;
         acc     <= '0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (hi_we) hi <= rs_val;
               if (lo_we) lo <= rs_val;
               if (start) begin
                  div_op  <= op[1];
                  neg_a   <= sa;
                  neg_b   <= sb;
                  dz      <= (rt_val == '0);
                  rs_orig <= rs_val;
                  mb      <= op[1] ? abs_rt : abs_rs;
                  acc     <= {{WIDTH{1'b0}}, op[1] ? abs_rs : abs_rt};
                  count   <= CW'(WIDTH - 1);
                  tail    <= 1'b0;
                  state   <= S_CALC;
               end
            end
            S_CALC: begin
               // After the last step one settle cycle precedes the sign fix.
               if (tail) begin
                  state <= S_FIX;
               end else begin
                  acc   <= div_op ? div_next : mul_next;
                  count <= count - CW'(1);
                  tail  <= (count == '0);
               end
            end
            S_FIX: begin
               hi    <= res_hi;
               lo    <= res_lo;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench for the HI/LO multiply/divide unit.
import mips_pkg::*;

module tb_mips_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hi_we;
   logic        lo_we;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   mips_muldiv_unit #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .op    (op),
      .rs_val(rs_val),
      .rt_val(rt_val),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clock = ~clock;

   // Drives one start pulse; returns #1 after the launch edge E.
   task automatic launch(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      @(negedge clock);
      op     = o;
      rs_val = a;
      rt_val = b;
      start  = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // Edges from now until done is seen (-1 if it never comes).
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clock);
         #1;
         if (done) begin
            lat = i;
            return;
         end
      end
   endtask

   task automatic test_reset;
      int seen;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got=%b exp=0", done);
      end
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0) begin
         failures++;
         $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo);
      end
      @(negedge clock);
      reset = 1'b0;
      rs_val = 32'h5555_AAAA;
      hi_we = 1'b1;
      lo_we = 1'b1;
      @(posedge clock);
      #1 hi_we = 1'b0;
      lo_we = 1'b0;
      checks++;
      if (hi !== 32'h5555_AAAA || lo !== 32'h5555_AAAA) begin
         failures++;
         $display("FAIL mthi_mtlo_both got=%h/%h exp=5555aaaa/5555aaaa",
                  hi, lo);
      end
      launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL midop_reset_ctl got=%b%b exp=00", busy, done);
      end
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0) begin
         failures++;
         $display("FAIL midop_reset_hilo got=%h/%h exp=0/0", hi, lo);
      end
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clock);
         #1 if (done) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL midop_reset_nodone got=%0d exp=0", seen);
      end
   endtask

   task automatic test_multu_latency;
      bit bad;
      launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      bad = (busy !== 1'b1) || (done !== 1'b0);
      for (int i = 1; i <= 33; i++) begin
         @(posedge clock);
         #1 if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL multu_busy_window got=bad exp=busy1_done0");
      end
      @(posedge clock);
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL multu_done_e34 got=d%b b%b exp=d1 b0", done, busy);
      end
      checks++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         failures++;
         $display("FAIL multu_result got=%h/%h exp=fffffffe/00000001",
                  hi, lo);
      end
      @(posedge clock);
      #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse got=%b exp=0", done);
      end
   endtask

   task automatic test_mult_signed;
      int lat;
      launch(MD_MULT, 32'hFFFF_FFFD, 32'd7);
      wait_done(lat);
      checks++;
      if (lat != 34) begin
         failures++;
         $display("FAIL mult_latency got=%0d exp=34", lat);
      end
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
         failures++;
         $display("FAIL mult_neg got=%h/%h exp=ffffffff/ffffffeb", hi, lo);
      end
   endtask

   task automatic test_divide;
      int lat;
      launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat);
      checks++;
      if (lat != 34 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         failures++;
         $display("FAIL div_neg got=%0d %h/%h exp=34 ffffffff/fffffffd",
                  lat, hi, lo);
      end
      launch(MD_DIVU, 32'd100, 32'd7);
      wait_done(lat);
      checks++;
      if (hi !== 32'd2 || lo !== 32'd14) begin
         failures++;
         $display("FAIL divu got=%h/%h exp=2/e", hi, lo);
      end
   endtask

   task automatic test_div_edges;
      int lat;
      launch(MD_DIVU, 32'h0000_1234, 32'h0);
      wait_done(lat);
      checks++;
      if (lat != 34 || hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL div_by_zero got=%0d %h/%h exp=34 1234/ffffffff",
                  lat, hi, lo);
      end
      launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat);
      checks++;
      if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
         failures++;
         $display("FAIL div_min_neg1 got=%h/%h exp=0/80000000", hi, lo);
      end
   endtask

   task automatic test_ignore_while_busy;
      int lat;
      launch(MD_MULTU, 32'd6, 32'd7);
      repeat (5) @(posedge clock);
      @(negedge clock);
      op     = MD_DIVU;
      rs_val = 32'd1000;
      rt_val = 32'd3;
      start  = 1'b1;
      lo_we  = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      lo_we = 1'b0;
      wait_done(lat);
      checks++;
      if (lat != 28 || hi !== 32'h0 || lo !== 32'd42) begin
         failures++;
         $display("FAIL busy_ignore got=%0d %h/%h exp=28 0/2a", lat, hi, lo);
      end
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL start_not_queued got=%b exp=0", busy);
      end
      @(negedge clock);
      rs_val = 32'hDEAD_BEEF;
      hi_we  = 1'b1;
      @(posedge clock);
      #1 hi_we = 1'b0;
      checks++;
      if (hi !== 32'hDEAD_BEEF || lo !== 32'd42) begin
         failures++;
         $display("FAIL mthi_idle got=%h/%h exp=deadbeef/2a", hi, lo);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      launch(MD_MULTU, 32'd3, 32'd5);
      wait_done(lat);
      checks++;
      if (lat != 34 || lo !== 32'd15) begin
         failures++;
         $display("FAIL b2b_first got=%0d %h exp=34 f", lat, lo);
      end
      op     = MD_MULT;
      rs_val = 32'hFFFF_FFFF;
      rt_val = 32'd5;
      start  = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_launch got=%b exp=1", busy);
      end
      wait_done(lat);
      checks++;
      if (lat != 34 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFB) begin
         failures++;
         $display("FAIL b2b_second got=%0d %h/%h exp=34 ffffffff/fffffffb",
                  lat, hi, lo);
      end
      @(negedge clock);
      op     = MD_MULTU;
      rs_val = 32'd2;
      rt_val = 32'd3;
      hi_we  = 1'b1;
      start  = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      hi_we = 1'b0;
      checks++;
      if (hi !== 32'd2) begin
         failures++;
         $display("FAIL start_mthi_write got=%h exp=2", hi);
      end
      wait_done(lat);
      checks++;
      if (hi !== 32'h0 || lo !== 32'd6) begin
         failures++;
         $display("FAIL start_mthi_result got=%h/%h exp=0/6", hi, lo);
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      op     = MD_MULT;
      rs_val = '0;
      rt_val = '0;
      hi_we  = 1'b0;
      lo_we  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      test_reset;
      test_multu_latency;
      test_mult_signed;
      test_divide;
      test_div_edges;
      test_ignore_while_busy;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
